// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-side bus between the hazard unit / instruction memory and fetch_stall_ctrl.
// The master modport is the environment; the slave modport is the fetch controller.
interface fetch_stall_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [31:0]      imem_rdata;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  IF_ID_PC;
  logic [31:0]      IF_ID_INSTR;
  logic             IF_ID_VALID;
  logic             ID_EX_BUBBLE;
  logic             misalign_err;
  logic [1:0]       fetch_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall, flush, redirect_pc, imem_rdata,
    input  imem_addr, IF_ID_PC, IF_ID_INSTR, IF_ID_VALID, ID_EX_BUBBLE,
           misalign_err, fetch_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, redirect_pc, imem_rdata,
    output imem_addr, IF_ID_PC, IF_ID_INSTR, IF_ID_VALID, ID_EX_BUBBLE,
           misalign_err, fetch_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// PC register and IF/ID pipeline register with stall/flush handling for the RV32I front end.
// Flush beats stall; stall beats normal advance. Event counters saturate for perf debug.
module fetch_stall_ctrl #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input logic               CLK,
  input logic               RSTN,
  fetch_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } fetch_state_e;

  fetch_state_e     state_r, state_nxt_s;
  logic [XLEN-1:0]  pc_r, pc_nxt_s;
  logic [XLEN-1:0]  if_id_pc_r, if_id_pc_nxt_s;
  logic [31:0]      if_id_instr_r, if_id_instr_nxt_s;
  logic             if_id_valid_r, if_id_valid_nxt_s;
  logic             bubble_r, bubble_nxt_s;
  logic             misalign_r, misalign_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r, stall_cnt_nxt_s;
  logic [CNT_W-1:0] flush_cnt_r, flush_cnt_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: BOOT always moves on; elsewhere flush > stall > advance
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN, HOLD, REDIR: begin
        if (bus.flush) begin
          state_nxt_s = REDIR;
        end else if (bus.stall) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // FSM outputs: next values for the PC, IF/ID register, bubble and counters
  always_comb begin
    pc_nxt_s          = pc_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_valid_nxt_s = if_id_valid_r;
    bubble_nxt_s      = 1'b1;
    misalign_nxt_s    = misalign_r;
    stall_cnt_nxt_s   = stall_cnt_r;
    flush_cnt_nxt_s   = flush_cnt_r;
    case (state_r)
      RUN, HOLD, REDIR: begin
        if (bus.flush) begin
          pc_nxt_s          = {bus.redirect_pc[XLEN-1:2], 2'b00};
          if_id_pc_nxt_s    = '0;
          if_id_instr_nxt_s = NOP_INSTR;
          if_id_valid_nxt_s = 1'b0;
          flush_cnt_nxt_s   = sat_inc(flush_cnt_r);
          misalign_nxt_s    = misalign_r | (|bus.redirect_pc[1:0]);
        end else if (bus.stall) begin
          stall_cnt_nxt_s   = sat_inc(stall_cnt_r);
        end else begin
          pc_nxt_s          = pc_r + XLEN'(4);
          if_id_pc_nxt_s    = pc_r;
          if_id_instr_nxt_s = bus.imem_rdata;
          if_id_valid_nxt_s = 1'b1;
          bubble_nxt_s      = 1'b0;
        end
      end
      default: begin
        bubble_nxt_s = 1'b1;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_r          <= RESET_PC[XLEN-1:0];
      if_id_pc_r    <= '0;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
      bubble_r      <= 1'b0;
      misalign_r    <= 1'b0;
      stall_cnt_r   <= '0;
      flush_cnt_r   <= '0;
    end else begin
      pc_r          <= pc_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
      bubble_r      <= bubble_nxt_s;
      misalign_r    <= misalign_nxt_s;
      stall_cnt_r   <= stall_cnt_nxt_s;
      flush_cnt_r   <= flush_cnt_nxt_s;
    end
  end

  assign bus.imem_addr    = pc_r;
  assign bus.IF_ID_PC     = if_id_pc_r;
  assign bus.IF_ID_INSTR  = if_id_instr_r;
  assign bus.IF_ID_VALID  = if_id_valid_r;
  assign bus.ID_EX_BUBBLE = bubble_r;
  assign bus.misalign_err = misalign_r;
  assign bus.fetch_state  = state_r;
  assign bus.stall_cnt    = stall_cnt_r;
  assign bus.flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: the driver queues hand-computed expected state per edge,
// a monitor pops and compares after every clock edge and on reset assertion.
module tb_fetch_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_REDIR = 2'd3;

  logic CLK;
  logic RSTN;

  fetch_stall_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();

  fetch_stall_ctrl #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013), .CNT_W(16)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus.slave)
  );

  // instruction memory: word is a fixed function of its address
  function automatic logic [31:0] iw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata = iw(bus.imem_addr);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        bub;
    logic        mis;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic exp_t mk(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                              input logic [31:0] instr, input logic valid, input logic bub,
                              input logic mis, input logic [1:0] st, input logic [15:0] sc,
                              input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.addr = addr; e.pc = pc; e.instr = instr; e.valid = valid;
    e.bub = bub; e.mis = mis; e.st = st; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] rpc,
                      input exp_t e);
    @(negedge CLK);
    bus.stall       = s;
    bus.flush       = f;
    bus.redirect_pc = rpc;
    sb_q.push_back(e);
    RSTN = r;
  endtask

  // monitor: compare DUT state against the oldest pending expectation
  always @(posedge CLK or negedge RSTN) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (bus.imem_addr !== e.addr || bus.IF_ID_PC !== e.pc || bus.IF_ID_INSTR !== e.instr ||
          bus.IF_ID_VALID !== e.valid || bus.ID_EX_BUBBLE !== e.bub ||
          bus.misalign_err !== e.mis || bus.fetch_state !== e.st ||
          bus.stall_cnt !== e.sc || bus.flush_cnt !== e.fc) begin
        fails++;
        $display("FAIL %s: got addr=%h pc=%h instr=%h v=%b bub=%b mis=%b st=%0d sc=%h fc=%h | want addr=%h pc=%h instr=%h v=%b bub=%b mis=%b st=%0d sc=%h fc=%h",
                 e.tag, bus.imem_addr, bus.IF_ID_PC, bus.IF_ID_INSTR, bus.IF_ID_VALID,
                 bus.ID_EX_BUBBLE, bus.misalign_err, bus.fetch_state, bus.stall_cnt, bus.flush_cnt,
                 e.addr, e.pc, e.instr, e.valid, e.bub, e.mis, e.st, e.sc, e.fc);
      end
    end
  end

  initial begin
    logic [15:0] sc;
    RSTN            = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = 32'h0000_0000;

    // reset and boot, then sequential fetch
    step(1'b0, 1'b0, 1'b0, 32'h0, mk("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, S_BOOT, 16'd0, 16'd0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("boot", 32'h0, 32'h0, NOP, 1'b0, 1'b1, 1'b0, S_RUN, 16'd0, 16'd0));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, mk("advance", 32'(i * 4 + 4), 32'(i * 4), iw(32'(i * 4)),
                                       1'b1, 1'b0, 1'b0, S_RUN, 16'd0, 16'd0));
    end

    // three-cycle stall at PC=0x10
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, mk("stall", 32'h10, 32'hC, iw(32'hC), 1'b1, 1'b1, 1'b0,
                                       S_HOLD, 16'(i), 16'd0));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("resume", 32'h14, 32'h10, iw(32'h10), 1'b1, 1'b0, 1'b0, S_RUN, 16'd3, 16'd0));

    // flush to 0x200
    step(1'b1, 1'b0, 1'b1, 32'h200, mk("flush", 32'h200, 32'h0, NOP, 1'b0, 1'b1, 1'b0, S_REDIR, 16'd3, 16'd1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("post_flush", 32'h204, 32'h200, iw(32'h200), 1'b1, 1'b0, 1'b0, S_RUN, 16'd3, 16'd1));

    // stall and flush together: flush wins, stall_cnt unchanged
    step(1'b1, 1'b1, 1'b1, 32'h80, mk("stall_flush", 32'h80, 32'h0, NOP, 1'b0, 1'b1, 1'b0, S_REDIR, 16'd3, 16'd2));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("post_sf", 32'h84, 32'h80, iw(32'h80), 1'b1, 1'b0, 1'b0, S_RUN, 16'd3, 16'd2));

    // misaligned redirect, then back-to-back flush keeps error sticky
    step(1'b1, 1'b0, 1'b1, 32'h103, mk("misalign", 32'h100, 32'h0, NOP, 1'b0, 1'b1, 1'b1, S_REDIR, 16'd3, 16'd3));
    step(1'b1, 1'b0, 1'b1, 32'h40, mk("reflush", 32'h40, 32'h0, NOP, 1'b0, 1'b1, 1'b1, S_REDIR, 16'd3, 16'd4));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("post_redir", 32'h44, 32'h40, iw(32'h40), 1'b1, 1'b0, 1'b1, S_RUN, 16'd3, 16'd4));

    // long stall: counter climbs from 3 to 0xFFFE, then saturates at 0xFFFF
    sc = 16'd3;
    for (int i = 0; i < 32'hFFFB; i++) begin
      sc = sc + 16'd1;
      step(1'b1, 1'b1, 1'b0, 32'h0, mk("stall_climb", 32'h44, 32'h40, iw(32'h40), 1'b1, 1'b1, 1'b1,
                                       S_HOLD, sc, 16'd4));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, mk("stall_sat", 32'h44, 32'h40, iw(32'h40), 1'b1, 1'b1, 1'b1,
                                       S_HOLD, 16'hFFFF, 16'd4));
    end

    // asynchronous reset mid-stall, then reboot
    step(1'b0, 1'b1, 1'b0, 32'h0, mk("async_rst", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, S_BOOT, 16'd0, 16'd0));
    step(1'b0, 1'b1, 1'b0, 32'h0, mk("rst_hold", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, S_BOOT, 16'd0, 16'd0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("reboot", 32'h0, 32'h0, NOP, 1'b0, 1'b1, 1'b0, S_RUN, 16'd0, 16'd0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk("refetch", 32'h4, 32'h0, iw(32'h0), 1'b1, 1'b0, 1'b0, S_RUN, 16'd0, 16'd0));

    repeat (3) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
